// File: rtl/rv_regfile_pkg.sv
// rtl/rv_regfile_pkg.sv - shared types and build constants for the integer register file (RV32E selects 16 registers)
package rv_regfile_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
`ifdef RV32E
  localparam int RF_REG_COUNT  = 16;
`else
  localparam int RF_REG_COUNT  = 32;
`endif

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic {CLEAR, RUN} regfile_state_t;

  // An index is backed by storage only if it is not x0 and lies inside the file.
  function automatic logic rf_idx_ok(input int unsigned idx, input int unsigned count);
    return (idx != 32'(REG_X0)) && (idx < count);
  endfunction

endpackage

// File: rtl/rv_regfile_if.sv
// rtl/rv_regfile_if.sv - decode/writeback bus of the register file
interface rv_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] i_rs1;
  logic [ADDR_WIDTH-1:0] i_rs2;
  logic [ADDR_WIDTH-1:0] i_rd;
  logic                  i_write;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_reg1_data;
  logic [DATA_WIDTH-1:0] o_reg2_data;
  logic                  o_ready;

  modport master (
    output i_rs1, i_rs2, i_rd, i_write, i_data,
    input  o_reg1_data, o_reg2_data, o_ready
  );

  modport slave (
    input  i_rs1, i_rs2, i_rd, i_write, i_data,
    output o_reg1_data, o_reg2_data, o_ready
  );
endinterface

// File: rtl/rv_regfile_clr.sv
// rtl/rv_regfile_clr.sv - post-reset clear sequencer: walks x1..xN-1 writing zero, then raises ready
module rv_regfile_clr
  import rv_regfile_pkg::*;
#(
  parameter int REG_COUNT  = RF_REG_COUNT,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  output logic [ADDR_WIDTH-1:0] o_clr_idx,
  output logic                  o_clr_we,
  output logic                  o_ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_COUNT - 1);

  regfile_state_t        state;
  logic [ADDR_WIDTH-1:0] count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= CLEAR;
      count   <= ADDR_WIDTH'(1);
      o_ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (count == LAST_IDX) begin
            state   <= RUN;
            o_ready <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        RUN: o_ready <= 1'b1;
      endcase
    end
  end

  assign o_clr_idx = count;
  assign o_clr_we  = (state == CLEAR);

endmodule

// File: rtl/rv_regfile.sv
// rtl/rv_regfile.sv - 2R1W integer register file with x0 hardwired to zero; REGFILE_BYPASS_EN enables write-through
module rv_regfile
  import rv_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int REG_COUNT  = RF_REG_COUNT,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  rv_regfile_if.slave   bus
);

  localparam int IDX_W = $clog2(REG_COUNT);

  logic [DATA_WIDTH-1:0] mem [REG_COUNT];

  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  clr_we;
  logic                  ready;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;

  rv_regfile_clr #(
    .REG_COUNT  (REG_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clr (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_clr_idx (clr_idx),
    .o_clr_we  (clr_we),
    .o_ready   (ready)
  );

  assign bus.o_ready = ready;

  // The clear sequencer owns the write port until it finishes; writeback is ignored meanwhile.
  always_comb begin
    wr_en   = clr_we;
    wr_idx  = IDX_W'(clr_idx);
    wr_data = '0;
    if (!clr_we) begin
      wr_en   = bus.i_write && rf_idx_ok(32'(bus.i_rd), REG_COUNT);
      wr_idx  = IDX_W'(bus.i_rd);
      wr_data = bus.i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] rs);
    if (!rf_idx_ok(32'(rs), REG_COUNT)) begin
      return '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (bus.i_write && (bus.i_rd == rs)) begin
      return bus.i_data;
    end
`endif
    return mem[IDX_W'(rs)];
  endfunction

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bus.o_reg1_data <= '0;
      bus.o_reg2_data <= '0;
    end else if (!ready) begin
      bus.o_reg1_data <= '0;
      bus.o_reg2_data <= '0;
    end else begin
      bus.o_reg1_data <= read_port(bus.i_rs1);
      bus.o_reg2_data <= read_port(bus.i_rs2);
    end
  end

endmodule

// File: tb/tb_rv_regfile.sv
// tb/tb_rv_regfile.sv - self-checking bench for rv_regfile (32-entry and 16-entry instances)
module tb_rv_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic rst16_n;

  rv_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) u_if ();
  rv_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) u_if16 ();

  rv_regfile u_dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (u_if)
  );

  rv_regfile #(.DATA_WIDTH(32), .REG_COUNT(16), .ADDR_WIDTH(5)) u_dut16 (
    .i_clk     (clk),
    .i_reset_n (rst16_n),
    .bus       (u_if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit sel, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic [31:0] data);
    if (sel) begin
      u_if16.i_rs1 = rs1; u_if16.i_rs2 = rs2; u_if16.i_rd = rd;
      u_if16.i_write = we; u_if16.i_data = data;
    end else begin
      u_if.i_rs1 = rs1; u_if.i_rs2 = rs2; u_if.i_rd = rd;
      u_if.i_write = we; u_if.i_data = data;
    end
  endtask

  // Called at a negedge: drive one cycle, expect the registered read one edge later.
  task automatic step(input bit sel, input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic we, input logic [31:0] data,
                      input logic [31:0] e1, input logic [31:0] e2);
    exp_t x;
    set_in(sel, rs1, rs2, rd, we, data);
    sb.push_back('{e1: e1, e2: e2});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({name, ".reg1"}, sel ? u_if16.o_reg1_data : u_if.o_reg1_data, x.e1);
    check({name, ".reg2"}, sel ? u_if16.o_reg2_data : u_if.o_reg2_data, x.e2);
    @(negedge clk);
    set_in(sel, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
  endtask

  // Called at a negedge right after reset release; counts edges until o_ready, optionally
  // issuing a write of x3=0xFF at clear cycle inject_at.
  task automatic count_ready(input bit sel, input int inject_at, output int n, output int nz);
    logic rdy;
    n  = 0;
    nz = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == inject_at) set_in(sel, 5'd5, 5'd3, 5'd3, 1'b1, 32'hFF);
      else                set_in(sel, 5'd5, 5'd3, 5'd0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      n++;
      rdy = sel ? u_if16.o_ready : u_if.o_ready;
      if (!rdy && ((sel ? u_if16.o_reg1_data : u_if.o_reg1_data) !== 32'h0 ||
                   (sel ? u_if16.o_reg2_data : u_if.o_reg2_data) !== 32'h0)) nz++;
      @(negedge clk);
      if (rdy) break;
    end
    set_in(sel, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
  endtask

  initial begin
    int n;
    int nz;
    rst_n   = 1'b0;
    rst16_n = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);

    vecs.push_back('{rs1: 5'd0,  rs2: 5'd0, rd: 5'd5,  we: 1'b1, data: 32'hDEADBEEF, e1: 32'h0,        e2: 32'h0});
    vecs.push_back('{rs1: 5'd5,  rs2: 5'd5, rd: 5'd0,  we: 1'b0, data: 32'h0,        e1: 32'hDEADBEEF, e2: 32'hDEADBEEF});
    vecs.push_back('{rs1: 5'd0,  rs2: 5'd0, rd: 5'd0,  we: 1'b1, data: 32'h12345678, e1: 32'h0,        e2: 32'h0});
    vecs.push_back('{rs1: 5'd0,  rs2: 5'd0, rd: 5'd0,  we: 1'b0, data: 32'h0,        e1: 32'h0,        e2: 32'h0});
    vecs.push_back('{rs1: 5'd0,  rs2: 5'd0, rd: 5'd7,  we: 1'b1, data: 32'h1,        e1: 32'h0,        e2: 32'h0});
    vecs.push_back('{rs1: 5'd5,  rs2: 5'd7, rd: 5'd7,  we: 1'b1, data: 32'hA5A5A5A5, e1: 32'hDEADBEEF,
                     e2: BYPASS ? 32'hA5A5A5A5 : 32'h1});
    vecs.push_back('{rs1: 5'd7,  rs2: 5'd7, rd: 5'd0,  we: 1'b0, data: 32'h0,        e1: 32'hA5A5A5A5, e2: 32'hA5A5A5A5});
    vecs.push_back('{rs1: 5'd31, rs2: 5'd0, rd: 5'd31, we: 1'b1, data: 32'hFFFFFFFF,
                     e1: BYPASS ? 32'hFFFFFFFF : 32'h0, e2: 32'h0});
    vecs.push_back('{rs1: 5'd31, rs2: 5'd6, rd: 5'd0,  we: 1'b0, data: 32'h0,        e1: 32'hFFFFFFFF, e2: 32'h0});
    vecs.push_back('{rs1: 5'd5,  rs2: 5'd0, rd: 5'd5,  we: 1'b0, data: 32'h11,       e1: 32'hDEADBEEF, e2: 32'h0});
    vecs.push_back('{rs1: 5'd5,  rs2: 5'd0, rd: 5'd0,  we: 1'b0, data: 32'h0,        e1: 32'hDEADBEEF, e2: 32'h0});

    repeat (3) @(negedge clk);
    check("reset.ready", 32'(u_if.o_ready), 32'h0);
    check("reset.reg1", u_if.o_reg1_data, 32'h0);
    check("reset.reg2", u_if.o_reg2_data, 32'h0);

    rst_n = 1'b1;
    count_ready(1'b0, -1, n, nz);
    check("clear.cycles", 32'(n), 32'd31);
    check("clear.outputs_zero", 32'(nz), 32'd0);

    for (int i = 1; i < 32; i++)
      step(1'b0, $sformatf("cleared.x%0d", i), 5'(i), 5'(32 - i), 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);

    foreach (vecs[i])
      step(1'b0, $sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].we,
           vecs[i].data, vecs[i].e1, vecs[i].e2);

    // Reset from RUN, then again at clear cycle 10; a write during the restarted clear is dropped.
    set_in(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("run_reset.ready", 32'(u_if.o_ready), 32'h0);
    check("run_reset.reg1", u_if.o_reg1_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_clear_reset.ready", 32'(u_if.o_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    count_ready(1'b0, 10, n, nz);
    check("reclear.cycles", 32'(n), 32'd31);
    check("reclear.outputs_zero", 32'(nz), 32'd0);
    step(1'b0, "reclear.x3_x5", 5'd3, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b0, "reclear.x31_x7", 5'd31, 5'd7, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);

    // 16-entry build: out-of-range writes dropped and must not alias low registers.
    rst16_n = 1'b1;
    count_ready(1'b1, -1, n, nz);
    check("rc16.clear.cycles", 32'(n), 32'd15);
    step(1'b1, "rc16.x15_cleared", 5'd15, 5'd1, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b1, "rc16.wr_x20", 5'd0, 5'd0, 5'd20, 1'b1, 32'h55, 32'h0, 32'h0);
    step(1'b1, "rc16.rd_x20_x4", 5'd20, 5'd4, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b1, "rc16.wr_x15", 5'd0, 5'd0, 5'd15, 1'b1, 32'h77, 32'h0, 32'h0);
    step(1'b1, "rc16.rd_x15", 5'd15, 5'd20, 5'd0, 1'b0, 32'h0, 32'h77, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
